// File: rtl/fast_spi_capture.sv
// fast_spi_capture: samples pad lanes a programmable delay after each SCK fall and packs them into a 32-bit FWFT FIFO.
// Define FAST_SPI_CAPTURE_PARTIAL_FLUSH_EN to push zero-padded partial words when csn rises.
module fast_spi_capture #(
   parameter int LANES      = 4,
   parameter int MAX_DELAY  = 7,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            sys_clock,
   input  logic                            reset,
   input  logic                            cfg_enable,
   input  logic [1:0]                      cfg_mode,
   input  logic [$clog2(MAX_DELAY+1)-1:0]  cfg_delay,
   input  logic                            sck_out_data,
   input  logic                            csn_out_data,
   input  logic [LANES-1:0]                io_in,
   output logic [LANES-1:0]                io_core_in,
   output logic                            rd_valid,
   input  logic                            rd_ready,
   output logic [31:0]                     rd_data,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   input  logic                            clear_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   logic sck_prev, csn_prev;
   logic [2*MAX_DELAY-1:0] dl;
   logic [2*MAX_DELAY+1:0] taps;
   logic [1:0] ev;
   int d_sel;
   logic [7:0] io8;
   logic [3:0] b;
   logic [31:0] ins, shreg, shreg_next;
   logic [5:0] cnt, cnt_next;
   logic word_done;
   logic push_v;
   logic [31:0] push_w;
   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic pop, full, wr_en, drop;
   // Each delay-line slot holds {end, fall}; both can never coincide since they need opposite csn levels.
   always_comb begin
      taps = {dl, ~csn_prev & csn_out_data, sck_prev & ~sck_out_data & ~csn_out_data & cfg_enable};
      d_sel = (int'(cfg_delay) > MAX_DELAY) ? MAX_DELAY : int'(cfg_delay);
      ev = taps[2*d_sel +: 2];
      io8 = '0;
      io8[LANES-1:0] = io_in;
      b = (cfg_mode == 2'd0) ? 4'd1 : (cfg_mode == 2'd1) ? 4'd2 : (cfg_mode == 2'd3 && LANES == 8) ? 4'd8 : 4'd4;
      ins = (cfg_mode == 2'd0) ? {31'b0, io8[1]} : {24'b0, io8 & 8'((9'd1 << b) - 9'd1)};
      shreg_next = (shreg << b) | ins;
      cnt_next = cnt + {2'b0, b};
      word_done = cnt_next >= 6'd32;
   end
   assign rd_valid = fifo_level != '0;
   assign rd_data = rd_valid ? mem[rd_ptr] : '0;
   assign pop = rd_valid & rd_ready;
   assign full = fifo_level == LW'(FIFO_DEPTH);
   assign wr_en = push_v & (~full | pop);
   assign drop = push_v & full & ~pop;
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         sck_prev <= 1'b1;
         csn_prev <= 1'b1;
         dl <= '0;
         io_core_in <= '0;
         cnt <= '0;
         shreg <= '0;
         push_v <= 1'b0;
         push_w <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_level <= '0;
         overflow <= 1'b0;
      end else begin
         sck_prev <= sck_out_data;
         csn_prev <= csn_out_data;
         dl <= taps[2*MAX_DELAY-1:0];
         push_v <= 1'b0;
         if (ev[0]) begin
            io_core_in <= io_in;
            push_v <= word_done;
            push_w <= shreg_next;
            cnt <= word_done ? 6'd0 : cnt_next;
            shreg <= word_done ? '0 : shreg_next;
         end else if (ev[1]) begin
`ifdef FAST_SPI_CAPTURE_PARTIAL_FLUSH_EN
            push_v <= cnt != 6'd0;
            push_w <= shreg << (6'd32 - cnt);
`endif
            cnt <= '0;
            shreg <= '0;
         end
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
         overflow <= drop | (overflow & ~clear_overflow);
      end
   end
   always_ff @(posedge sys_clock) begin
      if (wr_en) mem[wr_ptr] <= push_w;
   end
endmodule

// File: tb/tb_fast_spi_capture.sv
// tb_fast_spi_capture: randomized scoreboard bench for fast_spi_capture (LANES=8, MAX_DELAY=7, FIFO_DEPTH=8).
module tb_fast_spi_capture;
   logic sys_clock = 0, reset = 1, cfg_enable = 0, sck = 0, csn = 1, rd_ready = 0, clear_overflow = 0;
   logic [1:0] cfg_mode = 0;
   logic [2:0] cfg_delay = 0;
   logic [7:0] io_in = 0;
   logic [7:0] io_core_in;
   logic rd_valid, overflow;
   logic [31:0] rd_data;
   logic [3:0] fifo_level;
   int checks = 0, errors = 0, rd_mode = 0;
   logic [31:0] exp_q[$];
   logic [7:0] samp[$];
   bit mbits[$];

   fast_spi_capture #(.LANES(8), .MAX_DELAY(7), .FIFO_DEPTH(8)) dut (
      .sys_clock(sys_clock), .reset(reset), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
      .cfg_delay(cfg_delay), .sck_out_data(sck), .csn_out_data(csn), .io_in(io_in),
      .io_core_in(io_core_in), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow));

   always #5 sys_clock = ~sys_clock;

   // rd_mode: 0 never ready, 1 random, 2 always ready
   always @(posedge sys_clock) begin
      #2;
      rd_ready = (rd_mode == 2) ? 1'b1 : (rd_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   always @(negedge sys_clock) begin : monitor
      logic [31:0] e;
      if (!reset && rd_valid && rd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h, no word expected", rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
               errors++;
               $display("FAIL pop_word: got %h expected %h", rd_data, e);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   function automatic int bpm(input int m);
      return (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 8;
   endfunction

   function automatic logic [31:0] pack();
      logic [31:0] w = '0;
      foreach (mbits[j]) w = {w[30:0], mbits[j]};
      mbits.delete();
      return w;
   endfunction

   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic rand_fill(input int n);
      samp.delete();
      for (int i = 0; i < n; i++) samp.push_back(8'($urandom));
   endtask

   // Reference: every sample contributes its lanes MSB-first to a bit stream; 32 bits make a word.
   task automatic xfer(input int mode, input int d, input bit auto_exp, input bit drop,
                       input bit hook_clr, input bit hook_rdy, input bit no_end);
      int b, saved;
      if (auto_exp) begin
         b = bpm(mode);
         foreach (samp[k]) begin
            for (int i = b - 1; i >= 0; i--) mbits.push_back(mode == 0 ? samp[k][1] : samp[k][i]);
            if (mbits.size() == 32) begin
               if (drop) mbits.delete();
               else exp_q.push_back(pack());
            end
         end
`ifdef FAST_SPI_CAPTURE_PARTIAL_FLUSH_EN
         if (!no_end && mbits.size() != 0) begin
            while (mbits.size() < 32) mbits.push_back(1'b0);
            exp_q.push_back(pack());
         end
`endif
         mbits.delete();
      end
      cfg_mode = 2'(mode);
      cfg_delay = 3'(d);
      tick();
      csn = 0;
      sck = 0;
      tick();
      foreach (samp[k]) begin
         sck = 1;
         io_in = ~samp[k];
         tick();
         sck = 0;
         repeat (d) tick();
         io_in = samp[k];
         tick();
         chk("io_core_in", 32'(io_core_in), 32'(samp[k]));
      end
      saved = rd_mode;
      if (hook_clr) clear_overflow = 1;
      if (hook_rdy) rd_mode = 2;
      tick();
      clear_overflow = 0;
      rd_mode = saved;
      if (!no_end) begin
         csn = 1;
         repeat (d + 3) tick();
      end
   endtask

   task automatic drain();
      rd_mode = 2;
      for (int i = 0; i < 100 && fifo_level != 0; i++) tick();
      chk("drain_level", 32'(fifo_level), 0);
      chk("drain_scoreboard_empty", exp_q.size(), 0);
   endtask

   task automatic random_phase(input int count);
      int m, n, per;
      for (int t = 0; t < count; t++) begin
         m = $urandom_range(0, 3);
         per = 32 / bpm(m);
         n = per * $urandom_range(1, 2) + $urandom_range(0, per - 1);
         rand_fill(n);
         xfer(m, $urandom_range(0, 7), 1, 0, 0, 0, 0);
      end
   endtask

   initial begin
      logic [7:0] held;
      repeat (2) tick();
      chk("rst_io_core_in", 32'(io_core_in), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_fifo_level", 32'(fifo_level), 0);
      chk("rst_overflow", 32'(overflow), 0);
      reset = 0;
      cfg_enable = 1;
      rd_mode = 1;
      tick();
      samp = '{8'hFA, 8'h3B, 8'h5C};
`ifdef FAST_SPI_CAPTURE_PARTIAL_FLUSH_EN
      exp_q.push_back(32'hABC00000);
`endif
      xfer(2, 1, 0, 0, 0, 0, 0);
      samp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      exp_q.push_back(32'h12345678);
      xfer(2, 2, 0, 0, 0, 0, 0);
      samp.delete();
      for (int i = 0; i < 32; i++) samp.push_back((8'($urandom) & 8'hFD) | ((i % 2 == 0) ? 8'h02 : 8'h00));
      exp_q.push_back(32'hAAAAAAAA);
      xfer(0, 0, 0, 0, 0, 0, 0);
      samp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      exp_q.push_back(32'hDEADBEEF);
      xfer(3, 7, 0, 0, 0, 0, 0);
      random_phase(20);
      drain();
      chk("no_overflow_random", 32'(overflow), 0);
      rd_mode = 0;
      tick();
      for (int i = 0; i < 8; i++) begin
         rand_fill(8);
         xfer(2, $urandom_range(0, 7), 1, 0, 0, 0, 0);
      end
      rand_fill(8);
      xfer(2, 1, 1, 1, 0, 0, 0);
      chk("ovf_level", 32'(fifo_level), 8);
      chk("ovf_flag", 32'(overflow), 1);
      clear_overflow = 1;
      tick();
      clear_overflow = 0;
      chk("ovf_cleared", 32'(overflow), 0);
      rand_fill(8);
      xfer(2, 3, 1, 1, 1, 0, 0);
      chk("ovf_set_beats_clear", 32'(overflow), 1);
      chk("ovf_level_after_drop", 32'(fifo_level), 8);
      clear_overflow = 1;
      tick();
      clear_overflow = 0;
      rand_fill(8);
      xfer(2, 2, 1, 0, 0, 1, 0);
      chk("full_push_pop_level", 32'(fifo_level), 8);
      chk("full_push_pop_no_ovf", 32'(overflow), 0);
      drain();
      rd_mode = 0;
      tick();
      for (int i = 0; i < 3; i++) begin
         rand_fill(8);
         xfer(2, 1, 1, 0, 0, 0, 0);
      end
      rand_fill(3);
      xfer(2, 1, 1, 0, 0, 0, 1);
      chk("pre_reset_level", 32'(fifo_level), 3);
      reset = 1;
      tick();
      chk("mid_rst_io_core_in", 32'(io_core_in), 0);
      chk("mid_rst_rd_valid", 32'(rd_valid), 0);
      chk("mid_rst_rd_data", rd_data, 0);
      chk("mid_rst_fifo_level", 32'(fifo_level), 0);
      chk("mid_rst_overflow", 32'(overflow), 0);
      exp_q.delete();
      reset = 0;
      csn = 1;
      repeat (10) tick();
      chk("post_rst_level", 32'(fifo_level), 0);
      rd_mode = 1;
      cfg_enable = 0;
      cfg_mode = 2;
      cfg_delay = 1;
      held = io_core_in;
      tick();
      csn = 0;
      tick();
      for (int i = 0; i < 12; i++) begin
         sck = 1;
         io_in = 8'($urandom);
         tick();
         sck = 0;
         tick();
      end
      repeat (10) tick();
      chk("disabled_io_hold", 32'(io_core_in), 32'(held));
      chk("disabled_no_word", 32'(fifo_level), 0);
      csn = 1;
      repeat (5) tick();
      cfg_enable = 1;
      random_phase(4);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
